ifetch_axi_bridge: RTL and testbench
====================================

# ifetch_axi_bridge

Converts the instruction-fetch stage's SRAM-like request/addr_ok/data_ok interface into an AXI4 read-only master (AR and R channels). It sits directly downstream of the fetch stage's `inst_sram_*` outputs. It tracks a bounded number of outstanding reads and returns each instruction word with a registered `data_ok` pulse. Write-side fetch signals are accepted on the interface but never produce AXI traffic.

## Interface
- `MAX_OUTST`, default 2: maximum accepted-but-unreturned reads, legal range 1..7.
- `clk`  in  1: clock; all state updates on the rising edge.
- `resetn`  in  1: synchronous reset, active-low.
- `inst_sram_req`  in  1: fetch request valid.
- `inst_sram_wr`  in  1: ignored; must be 0.
- `inst_sram_size`  in  2: ignored; the AXI size is fixed at 4 bytes.
- `inst_sram_wstrb`  in  4: ignored.
- `inst_sram_wdata`  in  32: ignored.
- `inst_sram_addr`  in  32: physical fetch address.
- `inst_sram_addr_ok`  out  1: request accepted this cycle (combinational).
- `inst_sram_data_ok`  out  1: registered return pulse, one cycle per word.
- `inst_sram_rdata`  out  32: returned word; valid when `data_ok`=1.
- `inst_axi_err`  out  1: registered one-cycle pulse with `data_ok` when `rresp`≠0.
- `arid`  out  4: constant 0.
- `araddr`  out  32: AR address.
- `arlen`  out  8: constant 0.
- `arsize`  out  3: constant 3'b010.
- `arburst`  out  2: constant 2'b01.
- `arlock`  out  2: constant 0.
- `arcache`  out  4: constant 0.
- `arprot`  out  3: constant 0.
- `arvalid`  out  1: AR valid.
- `arready`  in  1: AR ready.
- `rid`  in  4: ignored; in-order return is required of the slave.
- `rdata`  in  32: R data.
- `rresp`  in  2: R response.
- `rlast`  in  1: ignored (single beat).
- `rvalid`  in  1: R valid.
- `rready`  out  1: constant 1.

## Operation
- **State.** `arvalid_r`, `araddr_r`, outstanding counter `cnt` (width clog2(MAX_OUTST+1)), and response registers `dok_r`, `rdata_r`, `err_r`.
- **AR FSM.**
  - IDLE (`arvalid_r`=0) and AR_WAIT (`arvalid_r`=1).
  - `addr_ok = inst_sram_req & (cnt < MAX_OUTST) & (~arvalid_r | arready)`.
  - On `addr_ok`: `araddr_r <= inst_sram_addr`, `arvalid_r <= 1` (AR_WAIT).
  - In AR_WAIT with `arready`=1 and no new `addr_ok`: `arvalid_r <= 0` (IDLE).
  - In AR_WAIT with `arready`=1 and a new `addr_ok`: stay in AR_WAIT with the new address (back-to-back).
  - While `arvalid_r`=1, `araddr` is held stable until `arready`.
- **Counter.**
  - `inc = addr_ok`; `dec = rvalid & (cnt != 0)`.
  - inc only: `cnt+1`. dec only: `cnt-1`. Both: unchanged.
  - The `cnt < MAX_OUTST` comparison uses the current `cnt`; a same-cycle return is not forwarded.
- **Response.**
  - `dok_r <= dec`. `rdata_r <= rdata` when `dec`. `err_r <= dec & (rresp != 2'b00)`.
  - Outputs: `inst_sram_data_ok = dok_r`, `inst_sram_rdata = rdata_r`, `inst_axi_err = err_r`.
  - Words return in acceptance order. On error, the word is still returned as-is.
- **Stray beats.** A beat with `rvalid`=1 while `cnt`=0 is consumed (`rready`=1) and dropped: no `data_ok`, no error.

## Timing
- **Reset values.** `arvalid`=0, `araddr`=0, `cnt`=0, `inst_sram_data_ok`=0, `inst_sram_rdata`=0, `inst_axi_err`=0. `rready`=1 and all AR constants hold their fixed values during reset.
- **Reset mid-operation.**
  - Pending AR is abandoned and the counter is cleared.
  - Beats that arrive later for pre-reset requests are dropped by the `cnt`=0 rule.
- **Latency.**
  - `addr_ok` in cycle N → `arvalid`=1 from N+1.
  - R handshake in cycle M → `data_ok`=1 in M+1 for exactly one cycle.
  - Minimum request-to-data is 3 cycles (`arready` and `rvalid` both at N+1 give `data_ok` at N+2).
- **Throughput.** One request per cycle while `arready`=1 and `cnt` < MAX_OUTST.
- **Full.** At `cnt`=MAX_OUTST, `addr_ok`=0 until the cycle after a return, because the counter has decremented by then.

## Test plan
- **Single fetch.** `req` with addr 0x1C000000 at cycle 0, `arready`=1, `rvalid` at cycle 2 with rdata 0x02800C0C → `addr_ok`@0, `arvalid`@1 with araddr 0x1C000000, `data_ok`@3 with rdata 0x02800C0C, `inst_axi_err`=0.
- **AR backpressure.** `arready`=0 for 4 cycles then 1, `req` held high → `araddr` stable over all AR_WAIT cycles. The second `addr_ok` occurs only in the `arready` cycle, with `cnt`=1.
- **Outstanding limit, MAX_OUTST=2.**
  - Three back-to-back requests with `arready`=1 and no R beats → `addr_ok` for requests 1–2 only.
  - The third request is accepted the cycle after the first R handshake.
  - Data returns in order: 0xAAAA0001, then 0xAAAA0002.
- **Simultaneous inc/dec.** At `cnt`=1, `addr_ok` and an R beat occur in the same cycle → `cnt` stays 1 and `data_ok` pulses next cycle.
- **Error and stray beats.**
  - An R beat with `rresp`=2'b10 → `data_ok` and `inst_axi_err` both pulse, with the word passed through.
  - An R beat at `cnt`=0 → no pulse on either output.
- **Reset mid-flight.** `resetn`=0 for one cycle with `cnt`=2 and `arvalid`=1 → next cycle `arvalid`=0 and `cnt`=0. Two late R beats produce no `data_ok`.

Source files
------------

// File: rtl/ifetch_axi_bridge.sv
// ifetch_axi_bridge
//   Bridges the fetch stage's SRAM-like request/addr_ok/data_ok interface onto
//   an AXI4 read-only master (AR + R channels). It allows up to MAX_OUTST
//   accepted-but-unreturned reads and returns each word with a registered
//   one-cycle data_ok pulse, in acceptance order.
//
// Ports
//   clk, resetn           : clock, synchronous active-low reset
//   inst_sram_req/addr    : fetch request and physical address
//   inst_sram_wr/size/
//   wstrb/wdata           : accepted but unused (fetch side never writes)
//   inst_sram_addr_ok     : request accepted this cycle (combinational)
//   inst_sram_data_ok     : registered return pulse, one per word
//   inst_sram_rdata       : returned word, valid with data_ok
//   inst_axi_err          : registered pulse alongside data_ok when rresp != OKAY
//   ar*                   : AXI read-address channel (single 4-byte INCR beats)
//   r*                    : AXI read-data channel (rready tied high)

module ifetch_axi_bridge #(
   parameter int MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch side
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [3:0]  inst_sram_wstrb,
   input  logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   output logic        inst_axi_err,
   // AXI AR channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI R channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);

   localparam int CNT_W = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   typedef enum logic {
      S_IDLE,
      S_AR_WAIT
   } ar_state_t;

   ar_state_t         state_q, state_d;
   logic [31:0]       araddr_q, araddr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              dok_q, dok_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              addr_ok;
   logic              inc;
   logic              dec;

   // Write-side fetch signals and the slave's ID/last are intentionally ignored:
   // the slave must return in order and every burst is a single beat.
   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                            inst_sram_wdata, rid, rlast};

   always_comb begin
      // A new request may be taken when there is room in the outstanding window
      // and the AR slot is either empty or being drained this very cycle.
      addr_ok = inst_sram_req & (cnt_q < MAX_CNT) & ((state_q == S_IDLE) | arready);
      inc     = addr_ok;
      // Beats arriving with nothing outstanding are strays (e.g. from before a
      // reset); they are consumed but never reported.
      dec     = rvalid & (cnt_q != '0);

      state_d  = state_q;
      araddr_d = araddr_q;
      if (addr_ok) begin
         state_d  = S_AR_WAIT;
         araddr_d = inst_sram_addr;
      end else if ((state_q == S_AR_WAIT) && arready) begin
         state_d  = S_IDLE;
      end

      cnt_d = cnt_q;
      case ({inc, dec})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      dok_d   = dec;
      rdata_d = dec ? rdata : rdata_q;
      err_d   = dec & (rresp != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         araddr_q <= '0;
         cnt_q    <= '0;
         dok_q    <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         cnt_q    <= cnt_d;
         dok_q    <= dok_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign inst_sram_addr_ok = addr_ok;
   assign inst_sram_data_ok = dok_q;
   assign inst_sram_rdata   = rdata_q;
   assign inst_axi_err      = err_q;

   assign arvalid = (state_q == S_AR_WAIT);
   assign araddr  = araddr_q;
   assign arid    = 4'd0;
   assign arlen   = 8'd0;
   assign arsize  = 3'b010;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign rready  = 1'b1;

endmodule

// File: tb/tb_ifetch_axi_bridge.sv
module tb_ifetch_axi_bridge;

   localparam int MAX_OUTST = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_sram_req;
   logic        inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [3:0]  inst_sram_wstrb;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        inst_axi_err;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int vectors     = 0;
   int miscompares = 0;
   bit started     = 0;

   always #5 clk = ~clk;

   ifetch_axi_bridge #(.MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
      .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
      .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr(inst_sram_addr),
      .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
      .inst_sram_rdata(inst_sram_rdata), .inst_axi_err(inst_axi_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   // ---------------- behavioural model ----------------
   // Outstanding reads are a FIFO of accepted addresses; the AR slot is a
   // single "address being offered" register.
   logic [31:0] m_q[$];
   logic        m_arv    = 1'b0;
   logic [31:0] m_araddr = '0;
   logic        m_dok    = 1'b0;
   logic [31:0] m_rdata  = '0;
   logic        m_err    = 1'b0;

   function automatic logic exp_addr_ok();
      return inst_sram_req && (m_q.size() < MAX_OUTST) && (!m_arv || arready);
   endfunction

   always @(posedge clk) begin : model
      bit ok;
      bit ret;
      if (!resetn) begin
         m_q.delete();
         m_arv    = 1'b0;
         m_araddr = '0;
         m_dok    = 1'b0;
         m_rdata  = '0;
         m_err    = 1'b0;
      end else begin
         ok  = exp_addr_ok();
         ret = rvalid && (m_q.size() > 0);
         if (ret) begin
            $display("return addr=%h data=%h resp=%0d", m_q[0], rdata, rresp);
            void'(m_q.pop_front());
         end
         if (ok) begin
            $display("accept addr=%h", inst_sram_addr);
            m_q.push_back(inst_sram_addr);
            m_arv    = 1'b1;
            m_araddr = inst_sram_addr;
         end else if (arready) begin
            m_arv = 1'b0;
         end
         m_dok = ret;
         if (ret) m_rdata = rdata;
         m_err = ret && (rresp != 2'b00);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (started) begin
         chk("m_addr_ok", 32'(inst_sram_addr_ok), 32'(exp_addr_ok()));
         chk("m_arvalid", 32'(arvalid), 32'(m_arv));
         chk("m_araddr", araddr, m_araddr);
         chk("m_data_ok", 32'(inst_sram_data_ok), 32'(m_dok));
         chk("m_rdata", inst_sram_rdata, m_rdata);
         chk("m_err", 32'(inst_axi_err), 32'(m_err));
         chk("m_consts", 32'({arid, arlen, arsize, arburst, arlock, arcache, arprot, rready}),
             32'({4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0, 1'b1}));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic req, input logic [31:0] addr, input logic ar_rdy,
                      input logic rv, input logic [31:0] rd, input logic [1:0] rr);
      inst_sram_req  = req;
      inst_sram_addr = addr;
      arready        = ar_rdy;
      rvalid         = rv;
      rdata          = rd;
      rresp          = rr;
   endtask

   initial begin
      resetn          = 1'b0;
      inst_sram_wr    = 1'b0;
      inst_sram_size  = 2'b10;
      inst_sram_wstrb = 4'h0;
      inst_sram_wdata = 32'h0;
      rid             = 4'h0;
      rlast           = 1'b1;
      drv(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      started = 1;
      @(negedge clk);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
      chk("rst_rdata", inst_sram_rdata, 32'd0);
      chk("rst_err", 32'(inst_axi_err), 32'd0);
      chk("rst_rready", 32'(rready), 32'd1);
      chk("rst_arsize", 32'(arsize), 32'd2);
      chk("rst_arburst", 32'(arburst), 32'd1);
      tick();
      resetn = 1'b1;

      // single fetch
      drv(1, 32'h1C000000, 1, 0, 0, 0);
      @(negedge clk); chk("sf_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("sf_arvalid", 32'(arvalid), 32'd1);
      chk("sf_araddr", araddr, 32'h1C000000);
      tick(); drv(0, 0, 1, 1, 32'h02800C0C, 0);
      tick(); drv(0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("sf_data_ok", 32'(inst_sram_data_ok), 32'd1);
      chk("sf_rdata", inst_sram_rdata, 32'h02800C0C);
      chk("sf_err", 32'(inst_axi_err), 32'd0);
      tick();
      @(negedge clk); chk("sf_pulse_end", 32'(inst_sram_data_ok), 32'd0);

      // AR backpressure
      tick(); drv(1, 32'h1C000010, 0, 0, 0, 0);
      @(negedge clk); chk("bp_ok0", 32'(inst_sram_addr_ok), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick(); drv(1, 32'h1C000014, 0, 0, 0, 0);
         @(negedge clk);
         chk("bp_hold_addr", araddr, 32'h1C000010);
         chk("bp_stall", 32'(inst_sram_addr_ok), 32'd0);
      end
      tick(); drv(1, 32'h1C000014, 1, 0, 0, 0);
      @(negedge clk); chk("bp_ok1", 32'(inst_sram_addr_ok), 32'd1);
      chk("bp_addr_at_rdy", araddr, 32'h1C000010);
      tick(); drv(0, 0, 1, 1, 32'h11110001, 0);
      @(negedge clk); chk("bp_addr2", araddr, 32'h1C000014);
      tick(); drv(0, 0, 1, 1, 32'h11110002, 0);
      @(negedge clk); chk("bp_rdata1", inst_sram_rdata, 32'h11110001);
      tick(); drv(0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("bp_rdata2", inst_sram_rdata, 32'h11110002);

      // outstanding limit
      tick(); drv(1, 32'h100, 1, 0, 0, 0);
      @(negedge clk); chk("lim_ok1", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(1, 32'h104, 1, 0, 0, 0);
      @(negedge clk); chk("lim_ok2", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(1, 32'h108, 1, 0, 0, 0);
      @(negedge clk); chk("lim_full", 32'(inst_sram_addr_ok), 32'd0);
      tick(); drv(1, 32'h108, 1, 1, 32'hAAAA0001, 0);
      @(negedge clk); chk("lim_no_fwd", 32'(inst_sram_addr_ok), 32'd0);
      tick(); drv(1, 32'h108, 1, 0, 0, 0);
      @(negedge clk); chk("lim_ok3", 32'(inst_sram_addr_ok), 32'd1);
      chk("lim_rdata1", inst_sram_rdata, 32'hAAAA0001);
      tick(); drv(0, 0, 1, 1, 32'hAAAA0002, 0);
      @(negedge clk); chk("lim_addr3", araddr, 32'h108);
      tick(); drv(0, 0, 1, 1, 32'hAAAA0003, 0);
      @(negedge clk); chk("lim_rdata2", inst_sram_rdata, 32'hAAAA0002);
      tick(); drv(0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("lim_rdata3", inst_sram_rdata, 32'hAAAA0003);

      // simultaneous inc/dec
      tick(); drv(1, 32'h200, 1, 0, 0, 0);
      tick(); drv(1, 32'h204, 1, 1, 32'h00000055, 0);
      @(negedge clk); chk("sim_ok", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(1, 32'h208, 1, 0, 0, 0);
      @(negedge clk); chk("sim_cnt_kept", 32'(inst_sram_addr_ok), 32'd1);
      chk("sim_data_ok", 32'(inst_sram_data_ok), 32'd1);
      tick(); drv(1, 32'h20C, 1, 0, 0, 0);
      @(negedge clk); chk("sim_full", 32'(inst_sram_addr_ok), 32'd0);
      tick(); drv(0, 0, 1, 1, 32'h66, 0);
      tick(); drv(0, 0, 1, 1, 32'h77, 0);
      tick(); drv(0, 0, 1, 0, 0, 0);

      // error beat, then stray beat
      tick(); drv(1, 32'h300, 1, 0, 0, 0);
      tick(); drv(0, 0, 1, 0, 0, 0);
      tick(); drv(0, 0, 1, 1, 32'hDEADBEEF, 2'b10);
      tick(); drv(0, 0, 1, 1, 32'hCAFEF00D, 2'b10);
      @(negedge clk); chk("err_data_ok", 32'(inst_sram_data_ok), 32'd1);
      chk("err_flag", 32'(inst_axi_err), 32'd1);
      chk("err_word", inst_sram_rdata, 32'hDEADBEEF);
      tick(); drv(0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("stray_data_ok", 32'(inst_sram_data_ok), 32'd0);
      chk("stray_err", 32'(inst_axi_err), 32'd0);
      chk("stray_rdata", inst_sram_rdata, 32'hDEADBEEF);

      // reset mid-flight
      tick(); drv(1, 32'h400, 1, 0, 0, 0);
      tick(); drv(1, 32'h404, 1, 0, 0, 0);
      tick(); drv(0, 0, 0, 0, 0, 0); resetn = 1'b0;
      @(negedge clk); chk("mr_pre_arvalid", 32'(arvalid), 32'd1);
      tick(); resetn = 1'b1; drv(0, 0, 0, 1, 32'h0000BAD1, 0);
      @(negedge clk); chk("mr_arvalid", 32'(arvalid), 32'd0);
      chk("mr_araddr", araddr, 32'd0);
      tick(); drv(0, 0, 0, 1, 32'h0000BAD2, 0);
      @(negedge clk); chk("mr_late1", 32'(inst_sram_data_ok), 32'd0);
      tick(); drv(1, 32'h500, 1, 0, 0, 0);
      @(negedge clk); chk("mr_late2", 32'(inst_sram_data_ok), 32'd0);
      chk("mr_ok1", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(1, 32'h504, 1, 0, 0, 0);
      @(negedge clk); chk("mr_ok2", 32'(inst_sram_addr_ok), 32'd1);
      tick(); drv(1, 32'h508, 1, 0, 0, 0);
      @(negedge clk); chk("mr_cnt_cleared", 32'(inst_sram_addr_ok), 32'd0);
      tick(); drv(0, 0, 1, 1, 32'h00000001, 0);
      tick(); drv(0, 0, 1, 1, 32'h00000002, 0);
      tick(); drv(0, 0, 1, 0, 0, 0);
      tick();
      tick();
      @(negedge clk);
      started = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
